// File: rtl/friet_lwc_block_packer_if.sv
// Word-stream input and block output bundle between the LWC input buffer,
// the block packer and the FRIET core.
interface friet_lwc_block_packer_if #(
  parameter int unsigned G_WIDTH = 32,
  parameter int unsigned G_WORDS = 4
);
  localparam int unsigned NB_W  = $clog2(G_WIDTH / 8) + 1;
  localparam int unsigned BLK_W = G_WIDTH * G_WORDS;
  localparam int unsigned SZ_W  = $clog2(BLK_W / 8) + 1;

  logic [G_WIDTH-1:0] din;
  logic               din_valid;
  logic               din_ready;
  logic               din_last;
  logic [NB_W-1:0]    din_bytes;
  logic [BLK_W-1:0]   dout;
  logic [SZ_W-1:0]    dout_size;
  logic               dout_last;
  logic               dout_valid;
  logic               dout_ready;

  // Environment side: produces words, consumes blocks.
  modport master (
    output din, din_valid, din_last, din_bytes, dout_ready,
    input  din_ready, dout, dout_size, dout_last, dout_valid
  );

  // Packer side.
  modport slave (
    input  din, din_valid, din_last, din_bytes, dout_ready,
    output din_ready, dout, dout_size, dout_last, dout_valid
  );
endinterface

// File: rtl/friet_lwc_block_packer.sv
// Packs G_WORDS input words into one FRIET permutation block, inserting the
// 0x01 pad byte after the last message byte and zero-filling the remainder.
module friet_lwc_block_packer #(
  parameter int unsigned G_WIDTH = 32,
  parameter int unsigned G_WORDS = 4
) (
  input logic                     clk,
  input logic                     rst,
  friet_lwc_block_packer_if.slave bus
);
  localparam int unsigned BPW       = G_WIDTH / 8;
  localparam int unsigned BLK_W     = G_WIDTH * G_WORDS;
  localparam int unsigned BLK_BYTES = BLK_W / 8;
  localparam int unsigned NB_W      = $clog2(BPW) + 1;
  localparam int unsigned SZ_W      = $clog2(BLK_BYTES) + 1;
  localparam int unsigned CNT_W     = (G_WORDS > 1) ? $clog2(G_WORDS) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [SZ_W-1:0]  size_q, size_d;
  logic             last_q, last_d;
  logic             din_ready_q, din_ready_d;
  logic             dout_valid_q, dout_valid_d;
  logic [NB_W-1:0]  nb;
  logic             accept;
  int unsigned      base;
  int unsigned      fill_end;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      blk_q        <= '0;
      size_q       <= '0;
      last_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      size_q       <= size_d;
      last_q       <= last_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next-state, slot write and padding.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    size_d   = size_q;
    last_d   = last_q;
    nb       = (bus.din_bytes > NB_W'(BPW)) ? NB_W'(BPW) : bus.din_bytes;
    accept   = bus.din_valid & din_ready_q;
    base     = 32'(cnt_q) * BPW;
    fill_end = base + BPW;

    case (state_q)
      FILL: begin
        if (accept) begin
          fill_end = base + (bus.din_last ? 32'(nb) : BPW);
          // Byte b counts from the block MSB; the pad byte sits at fill_end,
          // which for a full tail word lands in the MSB of the next slot.
          for (int unsigned b = 0; b < BLK_BYTES; b++) begin
            if (b >= base && b < fill_end)
              blk_d[BLK_W-1-8*b -: 8] = bus.din[G_WIDTH-1-8*(b-base) -: 8];
            else if (bus.din_last && b >= fill_end)
              blk_d[BLK_W-1-8*b -: 8] = (b == fill_end) ? 8'h01 : 8'h00;
          end
          if (bus.din_last) begin
            size_d  = size_q + SZ_W'(nb);
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            size_d = size_q + SZ_W'(BPW);
            if (cnt_q == CNT_W'(G_WORDS - 1)) begin
              cnt_d   = '0;
              last_d  = 1'b0;
              state_d = FULL;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      FULL: begin
        if (bus.dout_ready) begin
          blk_d   = '0;
          size_d  = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    din_ready_d  = (state_d == FILL);
    dout_valid_d = (state_d == FULL);
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout       = blk_q;
  assign bus.dout_size  = size_q;
  assign bus.dout_last  = last_q;
endmodule
